vending_machine: RTL and testbench

VENDING_MACHINE -- requirements
Module: vending_machine

---
 rtl/vending_machine.sv | 111 +++++++++++
 tb/tb_vending_machine.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// Coin-operated vending controller: Rs5/Rs10 coins, configurable price, one Rs5 change coin.
// Optional 16-bit saturating sales counter enabled by defining VM_SALES_COUNTER_EN.
module vending_machine #(
    parameter int unsigned PRICE_UNITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  coin,
    output logic        product,
    output logic        change,
    output logic        reject,
    output logic [3:0]  credit
`ifdef VM_SALES_COUNTER_EN
    ,
    output logic [15:0] sales_count
`endif
);

    // HAVE5 means "some credit held"; for the default price that is exactly one Rs5 coin.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        HAVE5 = 1'b1
    } state_t;

    localparam logic [4:0] PRICE_S = 5'(PRICE_UNITS);

    function automatic logic [4:0] coin_value(input logic [1:0] c);
        logic [4:0] v;
        case (c)
            2'b01:   v = 5'd1;
            2'b10:   v = 5'd2;
            default: v = 5'd0;
        endcase
        return v;
    endfunction

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] credit_r;
    logic [3:0] next_credit_s;
    logic [4:0] sum_s;
    logic       product_r;
    logic       change_r;
    logic       reject_r;
    logic       product_s;
    logic       change_s;
    logic       reject_s;

    // Next-state and pulse decode from the coin sampled at this edge.
    always_comb begin
        sum_s         = {1'b0, credit_r} + coin_value(coin);
        next_credit_s = credit_r;
        product_s     = 1'b0;
        change_s      = 1'b0;
        reject_s      = 1'b0;
        if (coin == 2'b11) begin
            reject_s = 1'b1;
        end else if (sum_s >= PRICE_S) begin
            product_s     = 1'b1;
            change_s      = (sum_s != PRICE_S);
            next_credit_s = 4'd0;
        end else begin
            next_credit_s = sum_s[3:0];
        end
        if (next_credit_s == 4'd0) begin
            next_state_s = IDLE;
        end else begin
            next_state_s = HAVE5;
        end
    end

    // State, credit and output pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            credit_r  <= 4'd0;
            product_r <= 1'b0;
            change_r  <= 1'b0;
            reject_r  <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            credit_r  <= next_credit_s;
            product_r <= product_s;
            change_r  <= change_s;
            reject_r  <= reject_s;
        end
    end

    assign product = product_r;
    assign change  = change_r;
    assign reject  = reject_r;
    assign credit  = credit_r;

`ifdef VM_SALES_COUNTER_EN
    logic [15:0] sales_r;

    // Saturating count of vends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sales_r <= 16'd0;
        end else if (product_s && (sales_r != 16'hFFFF)) begin
            sales_r <= sales_r + 16'd1;
        end else begin
            sales_r <= sales_r;
        end
    end

    assign sales_count = sales_r;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine (default price and a price-3 instance).
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] coin = 2'b00;
    logic [1:0] coin3 = 2'b00;
    logic       product, change, reject;
    logic [3:0] credit;
    logic       product3, change3, reject3;
    logic [3:0] credit3;
`ifdef VM_SALES_COUNTER_EN
    logic [15:0] sales_count;
    logic [15:0] sales_count3;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vending_machine dut (
        .clk(clk), .reset(reset), .coin(coin),
        .product(product), .change(change), .reject(reject), .credit(credit)
`ifdef VM_SALES_COUNTER_EN
        , .sales_count(sales_count)
`endif
    );

    vending_machine #(.PRICE_UNITS(3)) dut3 (
        .clk(clk), .reset(reset), .coin(coin3),
        .product(product3), .change(change3), .reject(reject3), .credit(credit3)
`ifdef VM_SALES_COUNTER_EN
        , .sales_count(sales_count3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [1:0] c);
        coin = c;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        coin  = 2'b01;
        tick();
        tick();
        checks++; if (credit !== 4'd0) begin errors++; $display("FAIL reset_credit: got %0d expected 0", credit); end
        checks++; if (product !== 1'b0) begin errors++; $display("FAIL reset_product: got %0b expected 0", product); end
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL reset_change: got %0b expected 0", change); end
        checks++; if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %0b expected 0", reject); end
`ifdef VM_SALES_COUNTER_EN
        checks++; if (sales_count !== 16'd0) begin errors++; $display("FAIL reset_sales: got %0d expected 0", sales_count); end
`endif
        coin  = 2'b00;
        reset = 1'b1;
    endtask

    task automatic test_rs5_pair();
        apply(2'b01);
        checks++; if (credit !== 4'd1) begin errors++; $display("FAIL rs5_first_credit: got %0d expected 1", credit); end
        checks++; if (product !== 1'b0) begin errors++; $display("FAIL rs5_first_product: got %0b expected 0", product); end
        apply(2'b01);
        checks++; if (product !== 1'b1) begin errors++; $display("FAIL rs5_second_product: got %0b expected 1", product); end
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL rs5_second_change: got %0b expected 0", change); end
        checks++; if (credit !== 4'd0) begin errors++; $display("FAIL rs5_second_credit: got %0d expected 0", credit); end
        apply(2'b00);
        checks++; if (product !== 1'b0) begin errors++; $display("FAIL rs5_idle_product: got %0b expected 0", product); end
    endtask

    task automatic test_rs10();
        apply(2'b10);
        checks++; if (product !== 1'b1) begin errors++; $display("FAIL rs10_product: got %0b expected 1", product); end
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL rs10_change: got %0b expected 0", change); end
        checks++; if (credit !== 4'd0) begin errors++; $display("FAIL rs10_credit: got %0d expected 0", credit); end
        apply(2'b00);
        checks++; if (product !== 1'b0) begin errors++; $display("FAIL rs10_idle_product: got %0b expected 0", product); end
    endtask

    task automatic test_change();
        apply(2'b01);
        apply(2'b10);
        checks++; if (product !== 1'b1) begin errors++; $display("FAIL change_product: got %0b expected 1", product); end
        checks++; if (change !== 1'b1) begin errors++; $display("FAIL change_change: got %0b expected 1", change); end
        checks++; if (credit !== 4'd0) begin errors++; $display("FAIL change_credit: got %0d expected 0", credit); end
        apply(2'b00);
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL change_pulse_end: got %0b expected 0", change); end
    endtask

    task automatic test_reject();
        apply(2'b01);
        apply(2'b11);
        checks++; if (reject !== 1'b1) begin errors++; $display("FAIL reject_pulse: got %0b expected 1", reject); end
        checks++; if (credit !== 4'd1) begin errors++; $display("FAIL reject_credit: got %0d expected 1", credit); end
        checks++; if (product !== 1'b0) begin errors++; $display("FAIL reject_product: got %0b expected 0", product); end
        apply(2'b01);
        checks++; if (product !== 1'b1) begin errors++; $display("FAIL reject_then_vend: got %0b expected 1", product); end
        checks++; if (reject !== 1'b0) begin errors++; $display("FAIL reject_pulse_end: got %0b expected 0", reject); end
        apply(2'b00);
    endtask

    task automatic test_async_reset();
        apply(2'b01);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (credit !== 4'd0) begin errors++; $display("FAIL async_reset_credit: got %0d expected 0", credit); end
        checks++; if (product !== 1'b0 || change !== 1'b0) begin errors++; $display("FAIL async_reset_pulses: got %0b%0b expected 00", product, change); end
        coin = 2'b00;
        tick();
        reset = 1'b1;
        apply(2'b01);
        checks++; if (credit !== 4'd1) begin errors++; $display("FAIL post_reset_credit: got %0d expected 1", credit); end
        checks++; if (product !== 1'b0) begin errors++; $display("FAIL post_reset_product: got %0b expected 0", product); end
        apply(2'b01);
        apply(2'b00);
    endtask

    task automatic test_back_to_back();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(2'b10);
            checks++; if (product !== 1'b1) begin errors++; $display("FAIL b2b_product_%0d: got %0b expected 1", i, product); end
            checks++; if (credit !== 4'd0) begin errors++; $display("FAIL b2b_credit_%0d: got %0d expected 0", i, credit); end
        end
`ifdef VM_SALES_COUNTER_EN
        checks++; if (sales_count !== 16'd3) begin errors++; $display("FAIL b2b_sales: got %0d expected 3", sales_count); end
`endif
        apply(2'b00);
        checks++; if (product !== 1'b0) begin errors++; $display("FAIL b2b_end_product: got %0b expected 0", product); end
    endtask

    task automatic test_price3();
        coin3 = 2'b10;
        tick();
        checks++; if (credit3 !== 4'd2) begin errors++; $display("FAIL p3_first_credit: got %0d expected 2", credit3); end
        checks++; if (product3 !== 1'b0) begin errors++; $display("FAIL p3_first_product: got %0b expected 0", product3); end
        tick();
        checks++; if (product3 !== 1'b1) begin errors++; $display("FAIL p3_second_product: got %0b expected 1", product3); end
        checks++; if (change3 !== 1'b1) begin errors++; $display("FAIL p3_second_change: got %0b expected 1", change3); end
        checks++; if (credit3 !== 4'd0) begin errors++; $display("FAIL p3_second_credit: got %0d expected 0", credit3); end
        coin3 = 2'b01;
        tick();
        tick();
        checks++; if (credit3 !== 4'd2 || product3 !== 1'b0) begin errors++; $display("FAIL p3_two_rs5: got credit %0d product %0b expected 2 0", credit3, product3); end
        tick();
        checks++; if (product3 !== 1'b1 || change3 !== 1'b0) begin errors++; $display("FAIL p3_exact_vend: got %0b%0b expected 10", product3, change3); end
        coin3 = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_rs5_pair();
        test_rs10();
        test_change();
        test_reject();
        test_async_reset();
        test_back_to_back();
        test_price3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
